pc_seq: RTL

Parametrised program-counter sequencer for the 6502-compatible CPU core. It replaces the bare increment-only PC with a unit that performs the reset/interrupt vector fetch by itself, and also provides absolute jump loading and relative branching. Relative branches include the 6502 page-cross fix-up cycle. The unit drives the CPU address bus during vector fetch and whenever the PC is the address source. Opcodes come from the decode/control logic.

---
 rtl/pc_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// pc_seq: 6502-style program counter sequencer with vector fetch,
// absolute jump loading and relative branches with page-cross fix-up.
module pc_seq #(
  parameter int          AW       = 16,
  parameter logic [15:0] VEC_BASE = 16'hFFFA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op,
  input  logic [7:0]    d_in,
  input  logic [1:0]    vec_sel,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          page_cross
);

  typedef enum logic [1:0] {
    VEC_LO,
    VEC_HI,
    RUN,
    FIX
  } state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_LOADL  = 3'b010;
  localparam logic [2:0] OP_LOADH  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_VECTOR = 3'b101;

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic [AW-1:0] r_pc, w_pc;
  logic [7:0]    r_lat, w_lat;
  logic [AW-9:0] r_hi, w_hi;

  logic [AW-1:0] w_vaddr;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_sum;

  assign w_vaddr = VEC_BASE[AW-1:0]
                 + {{(AW-3){1'b0}}, r_idx, 1'b0};
  assign w_off   = {{(AW-8){d_in[7]}}, d_in};
  assign w_sum   = r_pc + w_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= VEC_LO;
      r_idx   <= 2'd1;
      r_pc    <= '0;
      r_lat   <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_pc    <= w_pc;
      r_lat   <= w_lat;
      r_hi    <= w_hi;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_pc    = r_pc;
    w_lat   = r_lat;
    w_hi    = r_hi;
    unique case (r_state)
      VEC_LO: begin
        w_lat   = d_in;
        w_state = VEC_HI;
      end
      VEC_HI: begin
        w_pc    = {d_in[AW-9:0], r_lat};
        w_state = RUN;
      end
      FIX: begin
        w_pc    = {r_hi, r_pc[7:0]};
        w_state = RUN;
      end
      default: begin
        case (op)
          OP_INC:   w_pc  = r_pc + AW'(1);
          OP_LOADL: w_lat = d_in;
          OP_LOADH: w_pc  = {d_in[AW-9:0], r_lat};
          OP_BRANCH: begin
            if (w_sum[AW-1:8] == r_pc[AW-1:8]) begin
              w_pc = w_sum;
            end else begin
              // keep the stale page for one cycle, like the real 6502
              w_pc    = {r_pc[AW-1:8], w_sum[7:0]};
              w_hi    = w_sum[AW-1:8];
              w_state = FIX;
            end
          end
          OP_VECTOR: begin
            w_idx   = (vec_sel == 2'd3) ? 2'd2 : vec_sel;
            w_state = VEC_LO;
          end
          default: w_pc = r_pc;
        endcase
      end
    endcase
  end

  always_comb begin
    unique case (r_state)
      VEC_LO:  addr = w_vaddr;
      VEC_HI:  addr = w_vaddr + AW'(1);
      default: addr = r_pc;
    endcase
  end

  assign pc         = r_pc;
  assign busy       = (r_state != RUN);
  assign page_cross = (r_state == FIX);

endmodule
